decode_ctrl: RTL and testbench

//  Decode-stage controller for the 5-stage RV32 pipeline (lw, sw, R-type, I-ALU, beq, jal).

---
 rtl/decode_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_decode_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl.sv
// Decode-stage controller for a 5-stage RV32 pipeline: opcode decode, ID/EX control register,
// load-use stall sequencing, branch/jump flush and illegal-opcode trap.
module decode_ctrl #(
  parameter int unsigned STALL_CYCLES = 1,
  parameter bit          TRAP_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  input  logic        valid_d,
  input  logic        pc_src_e,
  input  logic        trap_clr,
  output logic [1:0]  immsrc_d,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_d,
  output logic        regwrite_e,
  output logic        memwrite_e,
  output logic [1:0]  resultsrc_e,
  output logic        alusrc_e,
  output logic        branch_e,
  output logic        jump_e,
  output logic [1:0]  aluop_e,
  output logic [2:0]  funct3_e,
  output logic        funct7b5_e,
  output logic [4:0]  rd_e,
  output logic        valid_e,
  output logic        illegal_trap,
  output logic [1:0]  dbg_state_o
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_STALL  = 2'd1;
  localparam logic [1:0] S_TRAP   = 2'd2;
  localparam logic [1:0] CNT_LOAD = 2'(STALL_CYCLES - 1);

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic [1:0] resultsrc;
    logic       alusrc;
    logic       branch;
    logic       jump;
    logic [1:0] aluop;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [4:0] rd;
    logic       valid;
  } idex_t;

  logic [1:0] state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  idex_t      idex_q, idex_d, dec;
  logic       legal, hz, stall, flush;
  logic       unused_instr_bits;

  assign unused_instr_bits = ^{instr_d[31], instr_d[29:25]};

  always_comb begin
    immsrc_d     = 2'b00;
    dec          = '0;
    legal        = 1'b1;
    dec.funct3   = instr_d[14:12];
    dec.funct7b5 = instr_d[30];
    dec.rd       = instr_d[11:7];
    case (instr_d[6:0])
      7'b0000011: begin
        dec.regwrite  = 1'b1;
        dec.resultsrc = 2'b01;
        dec.alusrc    = 1'b1;
      end
      7'b0100011: begin
        immsrc_d     = 2'b01;
        dec.memwrite = 1'b1;
        dec.alusrc   = 1'b1;
      end
      7'b0110011: begin
        dec.regwrite = 1'b1;
        dec.aluop    = 2'b10;
      end
      7'b0010011: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.aluop    = 2'b10;
      end
      7'b1100011: begin
        immsrc_d   = 2'b10;
        dec.branch = 1'b1;
        dec.aluop  = 2'b01;
      end
      7'b1101111: begin
        immsrc_d      = 2'b11;
        dec.regwrite  = 1'b1;
        dec.resultsrc = 2'b10;
        dec.jump      = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    // Without the trap, an illegal opcode travels down the pipe as a bubble.
    dec.valid = valid_d & legal;
  end

  assign hz = idex_q.valid && (idex_q.resultsrc == 2'b01) && (idex_q.rd != 5'd0) && valid_d &&
              ((instr_d[19:15] == idex_q.rd) || (instr_d[24:20] == idex_q.rd));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idex_d  = '0;
    stall   = 1'b0;
    flush   = 1'b0;
    case (state_q)
      S_RUN: begin
        if (pc_src_e) begin
          flush = 1'b1;
        end else if (hz) begin
          stall = 1'b1;
          cnt_d = CNT_LOAD;
          if (CNT_LOAD != 2'd0) state_d = S_STALL;
        end else if (valid_d && !legal && TRAP_EN) begin
          stall   = 1'b1;
          state_d = S_TRAP;
        end else begin
          idex_d = dec;
        end
      end
      S_STALL: begin
        if (pc_src_e) begin
          flush   = 1'b1;
          cnt_d   = 2'd0;
          state_d = S_RUN;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q - 2'd1;
          if (cnt_q <= 2'd1) state_d = S_RUN;
        end
      end
      S_TRAP: begin
        // A redirect from an older branch wins over the release; both drop the illegal instr.
        if (pc_src_e) begin
          flush   = 1'b1;
          state_d = S_RUN;
        end else begin
          stall = 1'b1;
          if (trap_clr) begin
            flush   = 1'b1;
            state_d = S_RUN;
          end
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      cnt_q   <= 2'd0;
      idex_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idex_q  <= idex_d;
    end
  end

  assign stall_f      = stall & ~reset;
  assign stall_d      = stall & ~reset;
  assign flush_d      = flush & ~reset;
  assign illegal_trap = (state_q == S_TRAP);
  assign dbg_state_o  = state_q;

  assign regwrite_e  = idex_q.regwrite;
  assign memwrite_e  = idex_q.memwrite;
  assign resultsrc_e = idex_q.resultsrc;
  assign alusrc_e    = idex_q.alusrc;
  assign branch_e    = idex_q.branch;
  assign jump_e      = idex_q.jump;
  assign aluop_e     = idex_q.aluop;
  assign funct3_e    = idex_q.funct3;
  assign funct7b5_e  = idex_q.funct7b5;
  assign rd_e        = idex_q.rd;
  assign valid_e     = idex_q.valid;

endmodule

// File: tb/tb_decode_ctrl.sv
// Bench for decode_ctrl: two instances (STALL_CYCLES 1 and 3) share stimulus; a scoreboard
// queue holds the hand-computed per-cycle output vector and a negedge monitor compares it.
module tb_decode_ctrl;

  localparam int W = 27;

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] STALL = 2'd1;
  localparam logic [1:0] TRAP  = 2'd2;

  // {regwrite, memwrite, resultsrc, alusrc, branch, jump, aluop, valid}
  localparam logic [9:0] EX_BUB = 10'b0_0_00_0_0_0_00_0;
  localparam logic [9:0] EX_LW  = 10'b1_0_01_1_0_0_00_1;
  localparam logic [9:0] EX_SW  = 10'b0_1_00_1_0_0_00_1;
  localparam logic [9:0] EX_R   = 10'b1_0_00_0_0_0_10_1;
  localparam logic [9:0] EX_I   = 10'b1_0_00_1_0_0_10_1;
  localparam logic [9:0] EX_BEQ = 10'b0_0_00_0_1_0_01_1;
  localparam logic [9:0] EX_JAL = 10'b1_0_10_0_0_1_00_1;

  localparam logic [31:0] IDLE  = 32'h0000_0000;
  localparam logic [31:0] LW5   = {12'h000, 5'd1, 3'b010, 5'd5, 7'b0000011};
  localparam logic [31:0] ADD6  = {7'b0000000, 5'd2, 5'd5, 3'b000, 5'd6, 7'b0110011};
  localparam logic [31:0] LW0   = {12'h000, 5'd1, 3'b010, 5'd0, 7'b0000011};
  localparam logic [31:0] ADD9  = {7'b0000000, 5'd0, 5'd0, 3'b000, 5'd9, 7'b0110011};
  localparam logic [31:0] SW    = {7'b0000000, 5'd5, 5'd1, 3'b010, 5'd4, 7'b0100011};
  localparam logic [31:0] JAL   = {20'h00000, 5'd1, 7'b1101111};
  localparam logic [31:0] ADDI8 = {12'd1, 5'd0, 3'b000, 5'd8, 7'b0010011};
  localparam logic [31:0] BEQ   = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd0, 7'b1100011};
  localparam logic [31:0] ILL   = 32'h0000_007F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr_d = IDLE;
  logic        valid_d = 1'b0;
  logic        pc_src_e = 1'b0;
  logic        trap_clr = 1'b0;

  logic [1:0] immsrc_1, rs_1, aop_1, st_1, immsrc_3, rs_3, aop_3, st_3;
  logic       sf_1, sd_1, fl_1, rw_1, mw_1, as_1, br_1, jp_1, f7_1, v_1, tr_1;
  logic       sf_3, sd_3, fl_3, rw_3, mw_3, as_3, br_3, jp_3, f7_3, v_3, tr_3;
  logic [2:0] f3_1, f3_3;
  logic [4:0] rd_1, rd_3;

  decode_ctrl #(.STALL_CYCLES(1), .TRAP_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .instr_d(instr_d), .valid_d(valid_d), .pc_src_e(pc_src_e),
    .trap_clr(trap_clr), .immsrc_d(immsrc_1), .stall_f(sf_1), .stall_d(sd_1), .flush_d(fl_1),
    .regwrite_e(rw_1), .memwrite_e(mw_1), .resultsrc_e(rs_1), .alusrc_e(as_1), .branch_e(br_1),
    .jump_e(jp_1), .aluop_e(aop_1), .funct3_e(f3_1), .funct7b5_e(f7_1), .rd_e(rd_1),
    .valid_e(v_1), .illegal_trap(tr_1), .dbg_state_o(st_1)
  );

  decode_ctrl #(.STALL_CYCLES(3), .TRAP_EN(1'b1)) dut3 (
    .clk(clk), .reset(reset), .instr_d(instr_d), .valid_d(valid_d), .pc_src_e(pc_src_e),
    .trap_clr(trap_clr), .immsrc_d(immsrc_3), .stall_f(sf_3), .stall_d(sd_3), .flush_d(fl_3),
    .regwrite_e(rw_3), .memwrite_e(mw_3), .resultsrc_e(rs_3), .alusrc_e(as_3), .branch_e(br_3),
    .jump_e(jp_3), .aluop_e(aop_3), .funct3_e(f3_3), .funct7b5_e(f7_3), .rd_e(rd_3),
    .valid_e(v_3), .illegal_trap(tr_3), .dbg_state_o(st_3)
  );

  logic [W-1:0] act_1, act_3;
  assign act_1 = {sf_1, sd_1, fl_1, tr_1, immsrc_1, rw_1, mw_1, rs_1, as_1, br_1, jp_1, aop_1, v_1,
                  f3_1, f7_1, rd_1, st_1};
  assign act_3 = {sf_3, sd_3, fl_3, tr_3, immsrc_3, rw_3, mw_3, rs_3, as_3, br_3, jp_3, aop_3, v_3,
                  f3_3, f7_3, rd_3, st_3};

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  string        tag_q[$];
  logic         sel_q[$];
  int           checks = 0;
  int           errors = 0;
  logic         sel3 = 1'b0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, m, a;
      string        t;
      logic         s;
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      t = tag_q.pop_front();
      s = sel_q.pop_front();
      a = s ? act_3 : act_1;
      checks++;
      if ((a & m) !== (e & m)) begin
        errors++;
        $display("FAIL %s (stall%0d) got %h want %h", t, s ? 3 : 1, a & m, e & m);
      end
    end
  end

  // driver: inputs for one cycle plus that cycle's expected outputs
  // fe = {stall_f, stall_d, flush_d, illegal_trap, immsrc_d}; ex/rd fields = ID/EX contents
  task automatic step(input string tag, input logic rst, input logic [31:0] ins, input logic vd,
                      input logic pcs, input logic tc, input logic [5:0] fe, input logic [9:0] ex,
                      input logic cf, input logic [2:0] f3, input logic f7, input logic [4:0] rd,
                      input logic [1:0] st);
    @(posedge clk);
    #1;
    reset    = rst;
    instr_d  = ins;
    valid_d  = vd;
    pc_src_e = pcs;
    trap_clr = tc;
    exp_q.push_back({fe, ex, f3, f7, rd, st});
    msk_q.push_back({16'hffff, {9{cf}}, 2'b11});
    tag_q.push_back(tag);
    sel_q.push_back(sel3);
  endtask

  initial begin
    // reset state, outputs gated while reset is high
    step("rst_hold",   1, SW,    1, 1, 1, 6'b000001, EX_BUB, 0, 3'b000, 0, 5'd0, RUN);
    step("rst_rel",    0, IDLE,  0, 0, 0, 6'b000000, EX_BUB, 0, 3'b000, 0, 5'd0, RUN);
    // load-use, one bubble
    step("lw5",        0, LW5,   1, 0, 0, 6'b000000, EX_BUB, 0, 3'b000, 0, 5'd0, RUN);
    step("hz_stall",   0, ADD6,  1, 0, 0, 6'b110000, EX_LW,  1, 3'b010, 0, 5'd5, RUN);
    step("hz_bubble",  0, ADD6,  1, 0, 0, 6'b000000, EX_BUB, 0, 3'b000, 0, 5'd0, RUN);
    step("add_issue",  0, IDLE,  0, 0, 0, 6'b000000, EX_R,   1, 3'b000, 0, 5'd6, RUN);
    // x0 never stalls; sw/jal/addi decode
    step("lw0",        0, LW0,   1, 0, 0, 6'b000000, EX_BUB, 0, 3'b000, 0, 5'd0, RUN);
    step("x0_nostall", 0, ADD9,  1, 0, 0, 6'b000000, EX_LW,  1, 3'b010, 0, 5'd0, RUN);
    step("sw_imm",     0, SW,    1, 0, 0, 6'b000001, EX_R,   1, 3'b000, 0, 5'd9, RUN);
    step("jal_imm",    0, JAL,   1, 0, 0, 6'b000011, EX_SW,  1, 3'b010, 0, 5'd4, RUN);
    step("addi_id",    0, ADDI8, 1, 0, 0, 6'b000000, EX_JAL, 1, 3'b000, 0, 5'd1, RUN);
    step("addi_ex",    0, IDLE,  0, 0, 0, 6'b000000, EX_I,   1, 3'b000, 0, 5'd8, RUN);
    // branch redirect
    step("beq_imm",    0, BEQ,   1, 0, 0, 6'b000010, EX_BUB, 0, 3'b000, 0, 5'd0, RUN);
    step("beq_flush",  0, ADD6,  1, 1, 0, 6'b001000, EX_BEQ, 1, 3'b000, 0, 5'd0, RUN);
    step("flush_bub",  0, IDLE,  0, 0, 0, 6'b000000, EX_BUB, 0, 3'b000, 0, 5'd0, RUN);
    // illegal opcode trap and release
    step("ill_enter",  0, ILL,   1, 0, 0, 6'b110000, EX_BUB, 0, 3'b000, 0, 5'd0, RUN);
    for (int i = 0; i < 5; i++)
      step("trap_hold", 0, ILL,  1, 0, 0, 6'b110100, EX_BUB, 0, 3'b000, 0, 5'd0, TRAP);
    step("trap_clr",   0, ILL,   1, 0, 1, 6'b111100, EX_BUB, 0, 3'b000, 0, 5'd0, TRAP);
    step("trap_out",   0, ADDI8, 1, 0, 0, 6'b000000, EX_BUB, 0, 3'b000, 0, 5'd0, RUN);
    step("post_trap",  0, IDLE,  0, 0, 0, 6'b000000, EX_I,   1, 3'b000, 0, 5'd8, RUN);
    // redirect together with release
    step("ill_enter2", 0, ILL,   1, 0, 0, 6'b110000, EX_BUB, 0, 3'b000, 0, 5'd0, RUN);
    step("trap_pcsrc", 0, ILL,   1, 1, 1, 6'b001100, EX_BUB, 0, 3'b000, 0, 5'd0, TRAP);
    step("trap_out2",  0, IDLE,  0, 0, 0, 6'b000000, EX_BUB, 0, 3'b000, 0, 5'd0, RUN);
    // async reset mid-TRAP, then mid-normal with a live ID/EX
    step("ill_enter3", 0, ILL,   1, 0, 0, 6'b110000, EX_BUB, 0, 3'b000, 0, 5'd0, RUN);
    step("trap_in3",   0, ILL,   1, 0, 0, 6'b110100, EX_BUB, 0, 3'b000, 0, 5'd0, TRAP);
    step("rst_trap",   1, ILL,   1, 0, 0, 6'b000000, EX_BUB, 0, 3'b000, 0, 5'd0, RUN);
    step("rst_rel2",   0, ADD6,  1, 0, 0, 6'b000000, EX_BUB, 0, 3'b000, 0, 5'd0, RUN);
    step("add_after",  0, ADDI8, 1, 0, 0, 6'b000000, EX_R,   1, 3'b000, 0, 5'd6, RUN);
    step("rst_async",  1, IDLE,  0, 0, 0, 6'b000000, EX_BUB, 0, 3'b000, 0, 5'd0, RUN);
    step("rst_rel3",   0, IDLE,  0, 0, 0, 6'b000000, EX_BUB, 0, 3'b000, 0, 5'd0, RUN);

    // STALL_CYCLES = 3 instance
    sel3 = 1'b1;
    step("s3_lw5",     0, LW5,   1, 0, 0, 6'b000000, EX_BUB, 0, 3'b000, 0, 5'd0, RUN);
    step("s3_hz",      0, ADD6,  1, 0, 0, 6'b110000, EX_LW,  1, 3'b010, 0, 5'd5, RUN);
    step("s3_stall2",  0, ADD6,  1, 0, 0, 6'b110000, EX_BUB, 0, 3'b000, 0, 5'd0, STALL);
    step("s3_stall3",  0, ADD6,  1, 0, 0, 6'b110000, EX_BUB, 0, 3'b000, 0, 5'd0, STALL);
    step("s3_resume",  0, ADD6,  1, 0, 0, 6'b000000, EX_BUB, 0, 3'b000, 0, 5'd0, RUN);
    step("s3_issue",   0, IDLE,  0, 0, 0, 6'b000000, EX_R,   1, 3'b000, 0, 5'd6, RUN);
    // redirect aborts STALL
    step("ab_lw5",     0, LW5,   1, 0, 0, 6'b000000, EX_BUB, 0, 3'b000, 0, 5'd0, RUN);
    step("ab_hz",      0, ADD6,  1, 0, 0, 6'b110000, EX_LW,  1, 3'b010, 0, 5'd5, RUN);
    step("ab_flush",   0, ADD6,  1, 1, 0, 6'b001000, EX_BUB, 0, 3'b000, 0, 5'd0, STALL);
    step("ab_run",     0, IDLE,  0, 0, 0, 6'b000000, EX_BUB, 0, 3'b000, 0, 5'd0, RUN);
    step("ab_idle",    0, IDLE,  0, 0, 0, 6'b000000, EX_BUB, 0, 3'b000, 0, 5'd0, RUN);
    // async reset mid-STALL
    step("rs_lw5",     0, LW5,   1, 0, 0, 6'b000000, EX_BUB, 0, 3'b000, 0, 5'd0, RUN);
    step("rs_hz",      0, ADD6,  1, 0, 0, 6'b110000, EX_LW,  1, 3'b010, 0, 5'd5, RUN);
    step("rst_stall",  1, ADD6,  1, 0, 0, 6'b000000, EX_BUB, 0, 3'b000, 0, 5'd0, RUN);
    step("rs_rel",     0, IDLE,  0, 0, 0, 6'b000000, EX_BUB, 0, 3'b000, 0, 5'd0, RUN);
    step("rs_addi",    0, ADDI8, 1, 0, 0, 6'b000000, EX_BUB, 0, 3'b000, 0, 5'd0, RUN);
    step("rs_issue",   0, IDLE,  0, 0, 0, 6'b000000, EX_I,   1, 3'b000, 0, 5'd8, RUN);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries never compared, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
